apb_requester: RTL
==================

# apb_requester

Parametrised APB4 requester: accepts one transfer at a time on a valid/ready request channel and drives the APB IDLE/SETUP/ACCESS sequence. It adds byte strobes, protection bits, a wait-state timeout and a back-pressurable response channel. It sits between an internal command source and any APB completer, including the dual-port memory slave.

## Interface
- ADDR_WIDTH, 10: paddr/req_addr width.
- DATA_WIDTH, 32: data width; must be a multiple of 8; STRB_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- pclk  in  1  single clock; all logic is on the rising edge.
- presetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both req_valid and req_ready are high.
- req_addr  in  ADDR_WIDTH  transfer address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  STRB_WIDTH  write byte strobes.
- req_prot  in  3  pprot value.
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_slverr  out  1  pslverr captured, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  STRB_WIDTH  APB strobes.
- pprot  out  3  APB protection bits.
- pready, pslverr  in  1  APB completer response.
- prdata  in  DATA_WIDTH  APB read data.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On acceptance, register addr/write/wdata/prot onto paddr/pwrite/pwdata/pprot.
  - pstrb = req_strb for writes and all-zero for reads.
  - Next state is SETUP.
- SETUP: psel=1, penable=0; next state is ACCESS unconditionally; timeout counter cleared.
- ACCESS: psel=1, penable=1.
  - pready=1: capture pslverr into rsp_slverr; capture prdata into rsp_rdata for reads (0 for writes); rsp_timeout=0; go to RESP.
  - pready=0: counter increments. When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0), abort: rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - pready=1 on the final permitted cycle wins over the timeout.
- RESP:
  - psel=penable=0, rsp_valid=1, req_ready=0.
  - Response fields stay stable until rsp_ready=1, then go to IDLE.
- paddr, pwrite, pwdata, pstrb, pprot:
  - stable from SETUP through the last ACCESS cycle;
  - hold their last values in RESP/IDLE until the next acceptance.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. Saturates; never wraps.
- One outstanding transfer only; req_ready stays low from acceptance until the response is consumed.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE. All outputs 0 except req_ready=1. Counter 0.
- Reset asserted mid-transfer: psel/penable drop immediately; any pending response is discarded.
- Acceptance at edge N: SETUP during cycle N+1, first ACCESS cycle N+2.
- Zero-wait completer: rsp_valid high from edge N+3.
- Each wait state adds one cycle.
- With rsp_ready held high, minimum period is 4 cycles per transfer: IDLE, SETUP, ACCESS, RESP.
- Timeout with TIMEOUT_CYCLES=T: the last ACCESS cycle is the T-th; rsp_valid is asserted on the following edge.
- req_valid may drop before acceptance; no request is latched unless the handshake occurs.

## Test plan
- Write, zero wait: addr 0x3FC, wdata 0xDEADBEEF, strb 0xF, prot 0b010 -> psel high 2 cycles, penable 1 cycle, pstrb 0xF; rsp_valid at edge N+3 with rdata 0, slverr 0.
- Read, 3 wait states: prdata 0x12345678 with pready on the 4th ACCESS cycle -> pstrb 0x0, APB signals stable throughout, rsp_rdata 0x12345678 at edge N+6.
- Completer error: write with pslverr=1 and pready=1 -> rsp_slverr=1, rsp_timeout=0.
- Timeout, TIMEOUT_CYCLES=16, pready stuck 0 -> exactly 16 penable cycles, then rsp_slverr=1, rsp_timeout=1, rdata 0.
- Timeout boundary: pready=1 on the 16th cycle -> normal completion, rsp_timeout=0.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp fields stable, req_ready=0, no new SETUP.
  - Assert presetn=0 mid-ACCESS -> psel/penable/rsp_valid 0 immediately, req_ready=1 after release.

Source files
------------

// File: rtl/apb_requester.sv
// APB4 requester: one transfer at a time from a valid/ready request channel,
// with byte strobes, protection bits, wait-state timeout and held response.
module apb_requester #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DATA_WIDTH-1:0]   prdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           cnt_inc;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    slverr_q, slverr_d;
  logic                    tout_q, tout_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    tout_d   = tout_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : '0;
          pprot_d  = req_prot;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // a completion on the last permitted cycle beats the timeout
        if (pready) begin
          slverr_d = pslverr;
          rdata_d  = pwrite_q ? '0 : prdata;
          tout_d   = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (TO_EN && (cnt_inc == TO_LIM)) begin
            slverr_d = 1'b1;
            tout_d   = 1'b1;
            rdata_d  = '0;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      tout_q   <= tout_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign rsp_timeout = tout_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;

endmodule
